// File: rtl/mc_fifo_mem.sv
// mc_fifo_mem: CH independent single-clock FIFOs sharing one RAM array.
// Each channel keeps its own AW+1 bit read and write pointers.
// The MSB of each pointer is a wrap bit, so full and empty can be told apart.
// Optional feature macro: MC_FIFO_COUNT_EN adds per-channel occupancy on O_COUNT.
module mc_fifo_mem #(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int CW = 2
) (
  input  logic                   I_CLK,
  input  logic                   I_RST_N,
  input  logic                   I_WR_EN,
  input  logic [CW-1:0]          I_WR_CH,
  input  logic [DW-1:0]          I_WR_DATA,
  input  logic                   I_RD_EN,
  input  logic [CW-1:0]          I_RD_CH,
  output logic [DW-1:0]          O_RD_DATA,
  output logic                   O_RD_VALID,
  output logic [(2**CW)-1:0]     O_FULL,
  output logic [(2**CW)-1:0]     O_EMPTY,
  output logic                   O_WR_ERR,
  output logic                   O_RD_ERR
`ifdef MC_FIFO_COUNT_EN
  ,
  output logic [(2**CW)*(AW+1)-1:0] O_COUNT
`endif
);

  localparam int CH    = 2**CW;
  localparam int DEPTH = 2**AW;
  localparam int PW    = AW + 1;

  logic [PW-1:0]    wr_ptr [CH];
  logic [PW-1:0]    rd_ptr [CH];
  logic [DW-1:0]    mem    [CH*DEPTH];

  logic [CH-1:0]    full;
  logic [CH-1:0]    empty;
  logic             wr_acc;
  logic             rd_acc;
  logic [CW+AW-1:0] wr_addr;
  logic [CW+AW-1:0] rd_addr;
  logic [PW-1:0]    wr_ptr_sel;
  logic [PW-1:0]    rd_ptr_sel;

  // Flags come straight from registered pointers, so they never see input glitches.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int n = 0; n < CH; n++) begin
      empty[n] = (wr_ptr[n] == rd_ptr[n]);
      full[n]  = (wr_ptr[n][AW-1:0] == rd_ptr[n][AW-1:0]) &&
                 (wr_ptr[n][AW] != rd_ptr[n][AW]);
    end
  end

  // Accept decisions use start-of-cycle flags only; a same-cycle pop never frees room for a push.
  always_comb begin
    wr_ptr_sel = wr_ptr[I_WR_CH];
    rd_ptr_sel = rd_ptr[I_RD_CH];
    wr_acc     = I_WR_EN && !full[I_WR_CH];
    rd_acc     = I_RD_EN && !empty[I_RD_CH];
    wr_addr    = {I_WR_CH, wr_ptr_sel[AW-1:0]};
    rd_addr    = {I_RD_CH, rd_ptr_sel[AW-1:0]};
  end

  // Per-channel pointer advance; pointers wrap naturally modulo 2**(AW+1).
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      for (int n = 0; n < CH; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
      end
    end else begin
      for (int n = 0; n < CH; n++) begin
        if (wr_acc && (I_WR_CH == CW'(n))) wr_ptr[n] <= wr_ptr[n] + PW'(1);
        if (rd_acc && (I_RD_CH == CW'(n))) rd_ptr[n] <= rd_ptr[n] + PW'(1);
      end
    end
  end

  // Shared RAM write port; contents are deliberately left unreset.
  // Accepted push and pop can never target the same word, so no bypass is needed.
  always_ff @(posedge I_CLK) begin
    if (wr_acc) mem[wr_addr] <= I_WR_DATA;
  end

  // Registered read data, valid strobe and error pulses.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_RD_DATA  <= '0;
      O_RD_VALID <= 1'b0;
      O_WR_ERR   <= 1'b0;
      O_RD_ERR   <= 1'b0;
    end else begin
      if (rd_acc) O_RD_DATA <= mem[rd_addr];
      O_RD_VALID <= rd_acc;
      O_WR_ERR   <= I_WR_EN && !wr_acc;
      O_RD_ERR   <= I_RD_EN && !rd_acc;
    end
  end

  assign O_FULL  = full;
  assign O_EMPTY = empty;

`ifdef MC_FIFO_COUNT_EN
  // Occupancy is the modular pointer difference, range 0..DEPTH.
  always_comb begin
    O_COUNT = '0;
    for (int n = 0; n < CH; n++) begin
      O_COUNT[n*PW +: PW] = wr_ptr[n] - rd_ptr[n];
    end
  end
`else
  // Occupancy is not exported in this build; flags alone describe each channel.
`endif

endmodule

// File: tb/tb_mc_fifo_mem.sv
// Bench for mc_fifo_mem: queue-based channel model plus directed literal checks.
module tb_mc_fifo_mem;
  localparam int DW = 32, AW = 4, CW = 2;
  localparam int CH = 4, DEPTH = 16, PW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr_en = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [DW-1:0] wr_data = '0;
  logic rd_en = 1'b0;
  logic [CW-1:0] rd_ch = '0;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic [CH-1:0] full, empty;
  logic wr_err, rd_err;
`ifdef MC_FIFO_COUNT_EN
  logic [CH*PW-1:0] count;
`endif

  always #5 clk = ~clk;

  mc_fifo_mem #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .I_CLK(clk), .I_RST_N(rst_n),
    .I_WR_EN(wr_en), .I_WR_CH(wr_ch), .I_WR_DATA(wr_data),
    .I_RD_EN(rd_en), .I_RD_CH(rd_ch),
    .O_RD_DATA(rd_data), .O_RD_VALID(rd_valid),
    .O_FULL(full), .O_EMPTY(empty),
    .O_WR_ERR(wr_err), .O_RD_ERR(rd_err)
`ifdef MC_FIFO_COUNT_EN
    , .O_COUNT(count)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per channel, outputs from queue rules.
  logic [DW-1:0] q [CH][$];
  logic e_valid, e_werr, e_rerr;
  logic [DW-1:0] e_data;
  bit m_wa, m_ra;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) q[c].delete();
      e_valid <= 1'b0;
      e_werr  <= 1'b0;
      e_rerr  <= 1'b0;
      e_data  <= '0;
    end else begin
      m_wa = wr_en && (q[wr_ch].size() < DEPTH);
      m_ra = rd_en && (q[rd_ch].size() != 0);
      e_werr  <= wr_en && !m_wa;
      e_rerr  <= rd_en && !m_ra;
      e_valid <= m_ra;
      if (m_ra) begin
        e_data <= q[rd_ch][0];
        void'(q[rd_ch].pop_front());
      end
      if (m_wa) q[wr_ch].push_back(wr_data);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    logic [CH-1:0] ee, ef;
    if (started) begin
      for (int c = 0; c < CH; c++) begin
        ee[c] = (q[c].size() == 0);
        ef[c] = (q[c].size() == DEPTH);
      end
      chk("cmp_empty", empty, ee);
      chk("cmp_full", full, ef);
      chk("cmp_valid", rd_valid, e_valid);
      chk("cmp_data", rd_data, e_data);
      chk("cmp_wr_err", wr_err, e_werr);
      chk("cmp_rd_err", rd_err, e_rerr);
`ifdef MC_FIFO_COUNT_EN
      for (int c = 0; c < CH; c++) chk("cmp_count", count[c*PW +: PW], q[c].size());
`endif
    end
  end

  // One cycle of stimulus: drive at the falling edge, return at the next one.
  task automatic step(input logic we, input logic [CW-1:0] wc, input logic [DW-1:0] wd,
                      input logic re, input logic [CW-1:0] rc);
    wr_en = we; wr_ch = wc; wr_data = wd;
    rd_en = re; rd_ch = rc;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic chk_count(input string name, input int c, input int exp);
`ifdef MC_FIFO_COUNT_EN
    chk(name, count[c*PW +: PW], exp);
`else
    chk(name, q[c].size(), exp);
`endif
  endtask

  task automatic fill_drain(input logic [CW-1:0] c, input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, c, base + DW'(i), 1'b0, '0);
    chk("wrap_full", full[c], 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, c);
      chk("wrap_valid", rd_valid, 1'b1);
      chk("wrap_data", rd_data, base + DW'(i));
    end
    idle();
    chk("wrap_empty", empty[c], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 started = 1'b1;
    chk("rst_empty", empty, 4'b1111);
    chk("rst_full", full, 4'b0000);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 32'h0);
    chk("rst_errs", {wr_err, rd_err}, 2'b00);
    chk_count("rst_count", 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Fill, overflow, drain on channel 2
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd2, 32'h100 + i, 1'b0, '0);
    chk("fill_full2", full, 4'b0100);
    chk_count("fill_count2", 2, 16);
    chk("model_fill", q[2].size(), 16);
    step(1'b1, 2'd2, 32'h1FF, 1'b0, '0);
    chk("ovf_wr_err", wr_err, 1'b1);
    chk("ovf_full2", full[2], 1'b1);
    chk_count("ovf_count2", 2, 16);
    idle();
    chk("ovf_pulse_once", wr_err, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, 2'd2);
      chk("drain_valid", rd_valid, 1'b1);
      chk("drain_data", rd_data, 32'h100 + i);
    end
    idle();
    chk("drain_valid_off", rd_valid, 1'b0);
    chk("drain_hold", rd_data, 32'h10F);
    chk("drain_empty", empty, 4'b1111);

    // Underflow on channel 1
    step(1'b0, '0, '0, 1'b1, 2'd1);
    chk("udf_rd_err", rd_err, 1'b1);
    chk("udf_valid", rd_valid, 1'b0);
    step(1'b1, 2'd1, 32'hC1, 1'b1, 2'd1);
    chk("udf_pp_rd_err", rd_err, 1'b1);
    chk("udf_pp_wr_err", wr_err, 1'b0);
    chk("udf_pp_valid", rd_valid, 1'b0);
    chk("udf_pp_empty1", empty[1], 1'b0);
    chk_count("udf_pp_count1", 1, 1);
    step(1'b1, 2'd1, 32'hC2, 1'b1, 2'd1);
    chk("same_ch_valid", rd_valid, 1'b1);
    chk("same_ch_data", rd_data, 32'hC1);
    chk_count("same_ch_count1", 1, 1);
    step(1'b0, '0, '0, 1'b1, 2'd1);
    chk("same_ch_data2", rd_data, 32'hC2);

    // Channel isolation
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 32'hA0 + i, 1'b0, '0);
      step(1'b1, 2'd3, 32'hB0 + i, 1'b0, '0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 2'd3);
      chk("iso_b", rd_data, 32'hB0 + i);
      chk("iso_mid_empty", empty[2:1], 2'b11);
      step(1'b0, '0, '0, 1'b1, 2'd0);
      chk("iso_a", rd_data, 32'hA0 + i);
      chk("iso_valid", rd_valid, 1'b1);
    end
    idle();
    chk("iso_all_empty", empty, 4'b1111);

    // Full with same-cycle pop on channel 0
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd0, 32'h200 + i, 1'b0, '0);
    step(1'b1, 2'd0, 32'h2FF, 1'b1, 2'd0);
    chk("fullpp_wr_err", wr_err, 1'b1);
    chk("fullpp_valid", rd_valid, 1'b1);
    chk("fullpp_data", rd_data, 32'h200);
    chk("fullpp_full0", full[0], 1'b0);
    chk_count("fullpp_count0", 0, 15);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, 2'd0);
      chk("fullpp_drain", rd_data, 32'h200 + i);
    end
    for (int r = 0; r < 3; r++) fill_drain(2'd0, 32'h300 + 32'(r * 16));

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 32'h400 + i, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 32'h480 + i, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 2'd0);
    chk("mid_pre_data", rd_data, 32'h400);
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 32'h4FF;
    rd_en = 1'b1; rd_ch = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", empty, 4'b1111);
    chk("mid_rst_full", full, 4'b0000);
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_data", rd_data, 32'h0);
    chk("mid_rst_errs", {wr_err, rd_err}, 2'b00);
    chk_count("mid_rst_count0", 0, 0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("post_rst_empty", empty, 4'b1111);
    step(1'b1, 2'd0, 32'h5A5, 1'b0, '0);
    step(1'b1, 2'd0, 32'h5A6, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 2'd0);
    chk("post_rst_first", rd_data, 32'h5A5);
    step(1'b0, '0, '0, 1'b1, 2'd0);
    chk("post_rst_second", rd_data, 32'h5A6);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
